// File: rtl/cache_array_ctrl.sv
// Control FSM for a direct-mapped write-back cache: hit, dirty-victim writeback and line fill.
// Define CACHE_PERF_CNT_EN to build saturating hit/miss counters; otherwise both read 0.
module cache_array_ctrl #(
  parameter int s_index   = 3,
  parameter int cnt_width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [s_index-1:0]   mem_index,
  output logic                 mem_resp,
  input  logic                 hit,
  input  logic                 valid_out,
  input  logic                 dirty_out,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  output logic [s_index-1:0]   arr_rindex,
  output logic [s_index-1:0]   arr_windex,
  output logic                 tag_load,
  output logic                 valid_load,
  output logic                 valid_in,
  output logic                 dirty_load,
  output logic                 dirty_in,
  output logic                 data_load,
  output logic                 data_sel,
  output logic                 pmem_addr_sel,
  output logic [cnt_width-1:0] hit_count,
  output logic [cnt_width-1:0] miss_count
);

  // state     | meaning
  // IDLE      | no access in progress
  // CHECK     | array outputs settled; resolve hit / miss
  // WRITEBACK | dirty victim line being written to pmem
  // FILL      | line being read from pmem into the arrays
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WRITEBACK = 2'd2,
    FILL      = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   req;

  assign req        = mem_read | mem_write;
  assign arr_rindex = mem_index;
  assign arr_windex = mem_index;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    tag_load      = 1'b0;
    valid_load    = 1'b0;
    valid_in      = 1'b0;
    dirty_load    = 1'b0;
    dirty_in      = 1'b0;
    data_load     = 1'b0;
    data_sel      = 1'b0;
    pmem_addr_sel = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_nxt = CHECK;
      end
      CHECK: begin
        if (!req) begin
          state_nxt = IDLE;
        end else if (hit) begin
          mem_resp  = 1'b1;
          state_nxt = IDLE;
          if (mem_write) begin
            data_load  = 1'b1;
            dirty_load = 1'b1;
            dirty_in   = 1'b1;
          end
        end else if (valid_out && dirty_out) begin
          state_nxt = WRITEBACK;
        end else begin
          state_nxt = FILL;
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        if (pmem_resp) begin
          dirty_load = 1'b1;
          state_nxt  = FILL;
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          data_load  = 1'b1;
          data_sel   = 1'b1;
          tag_load   = 1'b1;
          valid_load = 1'b1;
          valid_in   = 1'b1;
          dirty_load = 1'b1;
          state_nxt  = CHECK;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  localparam logic [cnt_width-1:0] cnt_one = {{(cnt_width-1){1'b0}}, 1'b1};

  // The CHECK revisit after a fill completes a miss, so it must not count as a hit.
  logic from_fill;
  logic hit_inc;
  logic miss_inc;

  assign hit_inc  = (state == CHECK) && mem_resp && !from_fill;
  assign miss_inc = (state == CHECK) && ((state_nxt == WRITEBACK) || (state_nxt == FILL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      from_fill  <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      from_fill <= (state == FILL);
      if (hit_inc && (hit_count != '1))   hit_count  <= hit_count + cnt_one;
      if (miss_inc && (miss_count != '1)) miss_count <= miss_count + cnt_one;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: doc/cache_array_ctrl.md
Name: cache_array_ctrl

Overview:
- Control FSM for a direct-mapped, write-back cache built from the team's single-cycle-read register arrays: tag, valid, dirty and data.
- Sequences array loads and read/write indices on a CPU hit, a dirty-victim writeback and a line fill from physical memory.
- Sits between the CPU-side memory interface and the cacheline adaptor.
- Contains no storage other than FSM state and the optional counters. The datapath supplies the compare results.

Parameters:
- s_index, 3, index width; arrays hold 2**s_index sets.
- cnt_width, 32, width of the performance counters (only used under PERF_CNT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- mem_read  in  1  CPU read request; held until mem_resp
- mem_write  in  1  CPU write request; held until mem_resp; never asserted together with mem_read
- mem_index  in  s_index  set index of the CPU address
- mem_resp  out  1  one-cycle completion pulse to the CPU
- hit  in  1  datapath: valid_out & (tag_out == cpu tag), combinational
- valid_out  in  1  valid bit of the indexed set
- dirty_out  in  1  dirty bit of the indexed set
- pmem_read  out  1  line-fill request to the adaptor
- pmem_write  out  1  line-writeback request to the adaptor
- pmem_resp  in  1  adaptor completion pulse
- arr_rindex  out  s_index  read index to all arrays
- arr_windex  out  s_index  write index to all arrays
- tag_load  out  1  tag array load
- valid_load  out  1  valid array load
- valid_in  out  1  valid array write data
- dirty_load  out  1  dirty array load
- dirty_in  out  1  dirty array write data
- data_load  out  1  data array load
- data_sel  out  1  data array source: 0 = CPU write merge, 1 = pmem line
- pmem_addr_sel  out  1  pmem address source: 0 = CPU tag, 1 = victim tag
- hit_count  out  cnt_width  hit counter (PERF_CNT_EN only)
- miss_count  out  cnt_width  miss counter (PERF_CNT_EN only)

Behaviour:
- Reset: async assert forces state IDLE. All outputs are 0, counters included. Deassertion is synchronous to clk.
- Reset mid-operation: any in-flight pmem transaction is abandoned. pmem_read and pmem_write drop immediately. No array loads occur.
- Indices: arr_rindex = arr_windex = mem_index in every state. This is combinational, so any array write always targets the set being read.
- Default output values in every state: loads 0, mem_resp 0, pmem_* 0, data_sel 0, pmem_addr_sel 0.
- IDLE:
  - (mem_read | mem_write) -> CHECK next cycle.
  - Otherwise stay in IDLE.
- CHECK (array outputs settled):
  - hit & mem_read: mem_resp = 1 -> IDLE.
  - hit & mem_write: mem_resp = 1, data_load = 1 (data_sel = 0), dirty_load = 1, dirty_in = 1 -> IDLE.
  - ~hit & valid_out & dirty_out -> WRITEBACK.
  - ~hit otherwise -> FILL.
  - Request dropped in CHECK (illegal per protocol): return to IDLE with no outputs asserted.
- WRITEBACK:
  - pmem_write = 1, pmem_addr_sel = 1, held until pmem_resp.
  - On pmem_resp: dirty_load = 1, dirty_in = 0 -> FILL.
- FILL:
  - pmem_read = 1, pmem_addr_sel = 0, held until pmem_resp.
  - On pmem_resp, same cycle: data_load = 1 (data_sel = 1), tag_load = 1, valid_load = 1 (valid_in = 1), dirty_load = 1 (dirty_in = 0) -> CHECK.
  - The revisit of CHECK then hits and completes the access; a write merges at that point.
- pmem_resp arriving in IDLE or CHECK is ignored.
- pmem_read and pmem_write are never asserted together.
- Latency, in cycles from request assertion to mem_resp:
  - Hit: 2.
  - Clean miss: 3 + fill wait.
  - Dirty miss: 4 + writeback wait + fill wait.
- mem_resp is exactly one cycle wide. A new request seen in the cycle after mem_resp is treated as a new access.

Optional Feature:
- Macro: CACHE_PERF_CNT_EN.
- Defined:
  - hit_count increments on every CHECK cycle that asserts mem_resp without having come from FILL.
  - miss_count increments on every CHECK -> WRITEBACK or CHECK -> FILL transition.
  - Both saturate at all-ones and clear on reset.
- Undefined: hit_count and miss_count are tied to 0 and no counter flops are inferred.

Test Plan:
- Reset during FILL with pmem_read = 1: assert rst -> pmem_read = 0 in the same cycle, state IDLE. No loads occur. After release, a read to index 3 proceeds from IDLE.
- Read hit at index 2 (hit = 1) -> mem_resp high exactly 2 cycles after mem_read rises, 1 cycle wide. No loads asserted.
- Write hit at index 5 -> data_load = 1, dirty_load = 1, dirty_in = 1, mem_resp = 1, all in one cycle.
- Clean miss at index 0 (valid_out = 0), pmem_resp after 4 cycles:
  - Fill cycle: data_sel = 1, tag_load, valid_load and dirty_load (dirty_in = 0) all asserted.
  - Then CHECK with hit = 1 -> mem_resp.
- Dirty miss at index 7 (valid = 1, dirty = 1):
  - pmem_write with pmem_addr_sel = 1 until pmem_resp, then dirty cleared.
  - pmem_read follows; pmem_write and pmem_read never overlap.
  - mem_resp after the fill.
- CACHE_PERF_CNT_EN: sequence of 3 hits + 2 misses -> hit_count = 3, miss_count = 2. Without the macro both read 0.
